// File: rtl/clock_set_controller.sv
// clock_set_controller: key debounce + RUN/SET_MIN/SET_HOUR mode FSM with plus/minus auto-repeat pulses and idle timeout (clk, reset, key[3:0] active-low -> mode[1:0], plus, minus, run_enable)
module clock_set_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000,
    parameter int TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    output logic [1:0] mode,
    output logic       plus,
    output logic       minus,
    output logic       run_enable
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {RUN = 2'b00, SET_MIN = 2'b01, SET_HOUR = 2'b10} mode_t;
    mode_t st, st_nxt;
    logic [3:0] s1, s2, lvl, deb, deb_q, press;
    logic [DW-1:0] dc [4];
    logic [HW-1:0] hp, hm;
    logic [IW-1:0] ic;
    logic arm_p, arm_m, mce, set, idle, tmo, ok_p, ok_m, act_p, act_m;
    always_comb begin
        lvl = ~s2;
        press = deb & ~deb_q;
        mce = press[3] | press[0];
        set = st != RUN;
        idle = set && deb == 4'b0;
        tmo = idle && ic == IW'(TIMEOUT_CYCLES - 1);
        ok_p = (arm_p | press[2]) & deb[2] & set & ~mce;
        ok_m = (arm_m | press[1]) & deb[1] & set & ~mce;
        act_p = ok_p & ~deb[1];
        act_m = ok_m & ~deb[2];
        st_nxt = press[0] ? RUN :
                 press[3] ? (st == RUN ? SET_MIN : st == SET_MIN ? SET_HOUR : RUN) :
                 tmo ? RUN : st;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '1;
            s2 <= '1;
            deb <= '0;
            deb_q <= '0;
            for (int i = 0; i < 4; i++) dc[i] <= '0;
            hp <= '0;
            hm <= '0;
            arm_p <= 1'b0;
            arm_m <= 1'b0;
            ic <= '0;
            st <= RUN;
            plus <= 1'b0;
            minus <= 1'b0;
            run_enable <= 1'b1;
        end else begin
            s1 <= key;
            s2 <= s1;
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                deb[i] <= (lvl[i] != deb[i] && dc[i] == DW'(DEBOUNCE_CYCLES - 1)) ? lvl[i] : deb[i];
                dc[i] <= (lvl[i] == deb[i] || dc[i] == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : dc[i] + 1'b1;
            end
            hp <= act_p ? (hp == HW'(HOLD_CYCLES) ? HW'(HOLD_CYCLES - REPEAT_CYCLES + 1) : hp + 1'b1) : '0;
            hm <= act_m ? (hm == HW'(HOLD_CYCLES) ? HW'(HOLD_CYCLES - REPEAT_CYCLES + 1) : hm + 1'b1) : '0;
            plus <= act_p & (press[2] | hp == HW'(HOLD_CYCLES));
            minus <= act_m & (press[1] | hm == HW'(HOLD_CYCLES));
            arm_p <= ok_p;
            arm_m <= ok_m;
            ic <= (idle && !tmo) ? ic + 1'b1 : '0;
            st <= st_nxt;
            run_enable <= st_nxt == RUN;
        end
    end
    assign mode = st;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: random and directed stimulus, per-cycle scoreboard against a timestamp-based reference model
module tb_clock_set_controller;
    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 5;
    localparam int T = 100;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] key = 4'hF;
    logic [1:0] mode;
    logic plus, minus, run_enable;
    int errors = 0;
    int checks = 0;
    logic [4:0] q[$];
    always #5 clk = ~clk;
    clock_set_controller #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES(H),
        .REPEAT_CYCLES(R),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key(key),
        .mode(mode),
        .plus(plus),
        .minus(minus),
        .run_enable(run_enable)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // Reference model: a key is accepted once its synchronised level has been
    // steady for D samples; everything else is derived from event timestamps.
    logic [D+1:0] hist [4];
    logic [D-1:0] w;
    logic [3:0] deb_m, debp_m, pr, nd;
    logic mce_m;
    logic [1:0] pul;
    int n_m, mode_m, nm, lbusy, r, t;
    int pp [2];
    int lbad [2];
    int lconf [2];
    function automatic int kk(input int j);
        return j == 0 ? 2 : 1;
    endfunction
    function automatic int oo(input int j);
        return j == 0 ? 1 : 2;
    endfunction
    task automatic stamp();
        pr = deb_m & ~debp_m;
        mce_m = pr[3] | pr[0];
        for (int j = 0; j < 2; j++) begin
            if (pr[kk(j)]) pp[j] = n_m;
            if (!deb_m[kk(j)] || mode_m == 0 || mce_m) lbad[j] = n_m;
            if (deb_m[oo(j)]) lconf[j] = n_m;
        end
        if (mode_m == 0 || deb_m != 4'b0) lbusy = n_m;
    endtask
    always @(posedge clk) begin
        if (reset) begin
            n_m = 0;
            for (int k = 0; k < 4; k++) hist[k] = '0;
            deb_m = '0;
            debp_m = '0;
            mode_m = 0;
            lbusy = -1;
            for (int j = 0; j < 2; j++) begin
                pp[j] = -1;
                lbad[j] = -1;
                lconf[j] = -1;
            end
            stamp();
            q.push_back(5'b00001);
        end else begin
            pr = deb_m & ~debp_m;
            nm = pr[0] ? 0 : pr[3] ? (mode_m + 1) % 3 : (mode_m != 0 && n_m - lbusy == T) ? 0 : mode_m;
            for (int j = 0; j < 2; j++) begin
                r = pp[j] > lconf[j] + 1 ? pp[j] : lconf[j] + 1;
                t = n_m - r;
                pul[j] = (pp[j] > lbad[j]) && !deb_m[oo(j)] &&
                         ((t == 0 && pp[j] > lconf[j]) || (t >= H && (t - H) % R == 0));
            end
            q.push_back({2'(nm), pul[0], pul[1], nm == 0});
            n_m++;
            for (int k = 0; k < 4; k++) begin
                hist[k] = {hist[k][D:0], ~key[k]};
                w = hist[k][D+1:2];
                nd[k] = (&w) ? 1'b1 : (~|w) ? 1'b0 : deb_m[k];
            end
            debp_m = deb_m;
            deb_m = nd;
            mode_m = nm;
            stamp();
        end
    end
    always @(posedge clk) begin
        #1;
        if (q.size() == 0) chk("sb_empty", 32'(q.size()), 1);
        else chk("cycle_out", {mode, plus, minus, run_enable}, q.pop_front());
    end
    task automatic idle(input int c);
        repeat (c) @(negedge clk);
    endtask
    task automatic hold(input logic [3:0] k, input int c);
        key = k;
        idle(c);
        key = 4'hF;
    endtask
    task automatic run_cnt(input int c, output int pc, output int mc, output int first);
        pc = 0;
        mc = 0;
        first = 0;
        for (int i = 1; i <= c; i++) begin
            @(negedge clk);
            pc += int'(plus);
            mc += int'(minus);
            if ((plus || minus) && first == 0) first = i;
        end
    endtask
    logic [3:0] pats [8] = '{4'hF, 4'h7, 4'hB, 4'hD, 4'h9, 4'hE, 4'h6, 4'hF};
    int pc, mc, fst, pc2, mc2, f2, k;
    initial begin
        idle(3);
        chk("reset_out", {mode, plus, minus, run_enable}, 5'b00001);
        reset = 1'b0;
        idle(5);
        for (int i = 0; i < 3; i++) begin
            hold(4'b0111, 12);
            idle(12);
            chk("mode_seq", mode, i == 0 ? 1 : i == 1 ? 2 : 0);
            chk("run_enable", run_enable, i == 2);
        end
        hold(4'b0111, 12);
        idle(12);
        for (int i = 0; i < 10; i++) begin
            key = i % 2 ? 4'hF : 4'b1011;
            idle(2);
        end
        key = 4'hF;
        run_cnt(10, pc, mc, fst);
        chk("bounce_no_plus", pc, 0);
        key = 4'b1011;
        run_cnt(10, pc, mc, fst);
        key = 4'hF;
        chk("one_plus", pc, 1);
        chk("press_latency", fst, 7);
        idle(12);
        hold(4'b0111, 12);
        idle(12);
        chk("set_hour", mode, 2);
        key = 4'b1101;
        run_cnt(38, pc, mc, fst);
        key = 4'hF;
        run_cnt(20, pc2, mc2, f2);
        chk("repeat_count", mc + mc2, 5);
        chk("repeat_first", fst, 7);
        chk("repeat_no_plus", pc + pc2, 0);
        hold(4'b0111, 12);
        idle(12);
        hold(4'b0111, 12);
        idle(12);
        key = 4'b1001;
        run_cnt(60, pc, mc, fst);
        key = 4'hF;
        chk("conflict_none", pc + mc, 0);
        idle(12);
        hold(4'b1110, 12);
        idle(12);
        key = 4'b1011;
        run_cnt(30, pc, mc, fst);
        key = 4'hF;
        chk("run_no_plus", pc, 0);
        idle(12);
        hold(4'b0111, 12);
        k = 0;
        for (int i = 1; i <= 200 && k == 0; i++) begin
            @(negedge clk);
            if (mode == 2'b00) k = i;
        end
        chk("timeout_cycles", k, 106);
        hold(4'b0111, 12);
        idle(12);
        hold(4'b0111, 12);
        idle(12);
        hold(4'b0110, 12);
        idle(12);
        chk("cancel_wins", mode, 0);
        hold(4'b0111, 12);
        idle(12);
        key = 4'b1011;
        idle(35);
        reset = 1'b1;
        idle(1);
        chk("reset_mid_mode", mode, 0);
        chk("reset_mid_plus", plus, 0);
        idle(1);
        reset = 1'b0;
        run_cnt(40, pc, mc, fst);
        key = 4'hF;
        chk("post_reset_no_plus", pc, 0);
        idle(12);
        for (int i = 0; i < 250; i++) begin
            key = $urandom_range(0, 3) == 0 ? 4'($urandom) : pats[$urandom_range(0, 7)];
            if ($urandom_range(0, 49) == 0) reset = 1'b1;
            idle(1);
            reset = 1'b0;
            idle($urandom_range(1, 45));
        end
        key = 4'hF;
        idle(20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
